// File: rtl/one_hot_decoder.sv
// One-hot to binary index decoder with a single-entry valid/ready output register.
// Flags zero-hot and multi-hot inputs and keeps a saturating count of them.
module one_hot_decoder #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDXW-1:0]  out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic             out_multi,
  output logic [15:0]      error_count,
  input  logic             error_clear
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             accept, transfer;
  logic [WIDTH-1:0] lowest;
  logic [IDXW-1:0]  idx_next;
  logic             zero_next, multi_next, error_in;
  logic [IDXW-1:0]  out_reg;
  logic             zero_reg, multi_reg;
  logic [15:0]      error_count_reg;

  assign out_valid = (state_reg == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  // Isolate the lowest set bit; the index is then a plain OR-encode of it.
  assign lowest     = in & (~in + ONE);
  assign zero_next  = (in == '0);
  assign multi_next = |(in & (in - ONE));
  assign error_in   = zero_next || multi_next;

  for (genvar gi = 0; gi < IDXW; gi++) begin : g_idx
    logic [WIDTH-1:0] mask;
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_bit
      assign mask[gj] = (((gj >> gi) % 2) == 1);
    end
    assign idx_next[gi] = |(lowest & mask);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (transfer && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      zero_reg  <= 1'b0;
      multi_reg <= 1'b0;
    end else if (accept) begin
      out_reg   <= idx_next;
      zero_reg  <= zero_next;
      multi_reg <= multi_next;
    end
  end

  // A clear coinciding with an erroneous accept leaves exactly that one error counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_count_reg <= '0;
    end else if (accept && error_in) begin
      if (error_clear) begin
        error_count_reg <= 16'd1;
      end else if (error_count_reg != 16'hFFFF) begin
        error_count_reg <= error_count_reg + 16'd1;
      end
    end else if (error_clear) begin
      error_count_reg <= '0;
    end
  end

  assign out         = out_reg;
  assign out_zero    = zero_reg;
  assign out_multi   = multi_reg;
  assign error_count = error_count_reg;

endmodule

// File: tb/tb_one_hot_decoder.sv
// Scoreboard bench for one_hot_decoder: a driver pushes reference results on accept,
// a negedge monitor compares whatever the decoder presents against the queue head.
module tb_one_hot_decoder;
  localparam int WIDTH = 8;
  localparam int IDXW  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_vec = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDXW-1:0]  out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_zero;
  logic             out_multi;
  logic [15:0]      error_count;
  logic             error_clear = 1'b0;

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic            zero;
    logic            multi;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   err_model = 0;
  int   n_xfer = 0;
  bit   verbose = 1'b1;

  one_hot_decoder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_vec),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_zero   (out_zero),
    .out_multi  (out_multi),
    .error_count(error_count),
    .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: scan bits from the bottom, count them, remember the first one seen.
  function automatic exp_t ref_model(input logic [WIDTH-1:0] v);
    exp_t r;
    int   cnt;
    int   first;
    cnt = 0;
    first = -1;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    r.idx   = (first < 0) ? '0 : first[IDXW-1:0];
    r.zero  = (cnt == 0);
    r.multi = (cnt > 1);
    return r;
  endfunction

  // One clock cycle: drive after the edge, decide accept at negedge, check count after next edge.
  task automatic step(input logic [WIDTH-1:0] v, input logic vld, input logic ordy,
                      input logic clr, output logic acc);
    exp_t e;
    in_vec = v;
    in_valid = vld;
    out_ready = ordy;
    error_clear = clr;
    @(negedge clk);
    acc = vld && in_ready;
    if (acc) begin
      e = ref_model(v);
      sb_q.push_back(e);
      if (e.zero || e.multi) begin
        err_model = clr ? 1 : ((err_model < 65535) ? err_model + 1 : 65535);
      end else if (clr) begin
        err_model = 0;
      end
    end else if (clr) begin
      err_model = 0;
    end
    @(posedge clk);
    #1;
    chk("error_count", 32'(error_count), 32'(err_model));
  endtask

  // Monitor: while out_valid the head must match (covers hold stability); pop on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stale_output: got out_valid=1 out=%0d, expected no pending output", out);
      end else begin
        chk("out_idx", 32'(out), 32'(sb_q[0].idx));
        chk("out_zero", 32'(out_zero), 32'(sb_q[0].zero));
        chk("out_multi", 32'(out_multi), 32'(sb_q[0].multi));
        if (out_ready) begin
          void'(sb_q.pop_front());
          n_xfer++;
          if (verbose)
            $display("xfer %0d: out=%0d zero=%0d multi=%0d err_cnt=%0d",
                     n_xfer, out, out_zero, out_multi, error_count);
        end
      end
    end
  end

  initial begin
    logic             acc;
    logic [WIDTH-1:0] v;
    int               r;

    // Reset state, asserted from time zero with no clock edge needed.
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_error_count", 32'(error_count), 0);
    in_valid = 1'b1;
    in_vec = 8'h04;
    @(posedge clk);
    #1;
    chk("rst_no_accept", 32'(out_valid), 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector, one-cycle latency.
    step(8'b0010_0000, 1'b1, 1'b1, 1'b0, acc);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_out", 32'(out), 5);

    // Back-to-back with no bubbles.
    step(8'h01, 1'b1, 1'b1, 1'b0, acc);
    chk("b2b0_out", 32'(out), 0);
    step(8'h80, 1'b1, 1'b1, 1'b0, acc);
    chk("b2b1_acc", 32'(acc), 1);
    chk("b2b1_out", 32'(out), 7);
    step(8'h04, 1'b1, 1'b1, 1'b0, acc);
    chk("b2b2_acc", 32'(acc), 1);
    chk("b2b2_out", 32'(out), 2);
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);

    // Backpressure: held output blocks the next vector until it transfers.
    step(8'h01, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(8'h02, 1'b1, 1'b0, 1'b0, acc);
      chk("stall_no_accept", 32'(acc), 0);
      chk("stall_hold_out", 32'(out), 0);
    end
    step(8'h02, 1'b1, 1'b1, 1'b0, acc);
    chk("stall_release_acc", 32'(acc), 1);
    chk("stall_next_out", 32'(out), 1);
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);

    // Zero and multi-hot flags, counting and clear.
    step(8'h00, 1'b1, 1'b1, 1'b0, acc);
    chk("zero_flag", 32'(out_zero), 1);
    chk("zero_out", 32'(out), 0);
    step(8'h0A, 1'b1, 1'b1, 1'b0, acc);
    chk("multi_flag", 32'(out_multi), 1);
    chk("multi_out", 32'(out), 1);
    chk("err_two", 32'(error_count), 2);
    step(8'h00, 1'b0, 1'b1, 1'b1, acc);
    chk("err_cleared", 32'(error_count), 0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) v = '0;
      else if (r == 1) v = 8'(32'h1 << $urandom_range(0, WIDTH - 1));
      else v = 8'($urandom);
      step(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), acc);
    end
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);

    // Saturation of the error counter.
    step(8'h00, 1'b0, 1'b1, 1'b1, acc);
    verbose = 1'b0;
    for (int i = 0; i < 65535; i++) step(8'h00, 1'b1, 1'b1, 1'b0, acc);
    chk("err_full", 32'(error_count), 32'hFFFF);
    step(8'h03, 1'b1, 1'b1, 1'b0, acc);
    chk("err_saturated", 32'(error_count), 32'hFFFF);
    step(8'h00, 1'b1, 1'b1, 1'b1, acc);
    chk("err_clear_with_error", 32'(error_count), 1);
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);
    verbose = 1'b1;

    // Reset while FULL: pending data vanishes at once and never reappears.
    step(8'h08, 1'b1, 1'b0, 1'b0, acc);
    chk("pre_rst_out", 32'(out), 3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_out", 32'(out), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    chk("async_rst_err", 32'(error_count), 0);
    sb_q.delete();
    err_model = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0, 1'b0, 1'b0, acc);
      chk("post_rst_no_valid", 32'(out_valid), 0);
    end
    step(8'h40, 1'b1, 1'b1, 1'b0, acc);
    chk("post_rst_out", 32'(out), 6);
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);
    step(8'h00, 1'b0, 1'b1, 1'b0, acc);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
